// File: rtl/rns_pkg.sv
// Shared constants for the {3,5,7} RNS reverse converter.
// Holds moduli, the mixed-radix inverse constants, datapath widths and FSM state encodings.
package rns_pkg;

  localparam int unsigned RES_W    = 3;    // residue width
  localparam int unsigned OUT_W    = 7;    // binary output width
  localparam int unsigned RED_W    = 6;    // width of values fed to the mod reducer

  localparam int unsigned M1       = 3;
  localparam int unsigned M2       = 5;
  localparam int unsigned M3       = 7;
  localparam int unsigned MR_RANGE = M1 * M2 * M3;  // 105

  localparam int unsigned INV12    = 2;    // M1^-1 mod M2
  localparam int unsigned INV13    = 5;    // M1^-1 mod M3
  localparam int unsigned INV23    = 3;    // M2^-1 mod M3

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StA2   = 3'd1;
  localparam state_t StA3   = 3'd2;
  localparam state_t StAcc  = 3'd3;
  localparam state_t StOut  = 3'd4;

endpackage

// File: rtl/rns_mod_reduce.sv
// Combinational reduction of a 6-bit value modulo a constant modulus.
// Ports:
//   val_i  value to reduce (0..63)
//   res_o  val_i mod Modulus, truncated to the residue width
module rns_mod_reduce
  import rns_pkg::*;
#(
  parameter int unsigned Modulus = 3
) (
  input  logic [RED_W-1:0] val_i,
  output logic [RES_W-1:0] res_o
);

  logic [RED_W-1:0] rem;

  // Constant modulus, so synthesis folds this into a small lookup.
  always_comb begin
    rem   = val_i % RED_W'(Modulus);
    res_o = RES_W'(rem);
  end

endmodule

// File: rtl/rns_reverse_converter_seq.sv
// Sequential mixed-radix converter from residues (mod 3, 5, 7) to a binary value 0..104.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   residue triple handshake (ready only while idle)
//   r1, r2, r3          residues mod M1, M2, M3 (out-of-range values are reduced)
//   out_valid/out_ready result handshake; out_data is held until accepted
//   out_data            converted binary value
//   out_err             some input residue was >= its modulus for this result
module rns_reverse_converter_seq
  import rns_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] r1,
  input  logic [RES_W-1:0] r2,
  input  logic [RES_W-1:0] r3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int unsigned SW = RES_W + 1;  // subtract width, room for the +m correction

  state_t           state_q, state_d;
  logic [RES_W-1:0] q1_q, q1_d, q2_q, q2_d, q3_q, q3_d;
  logic             err_q, err_d;
  logic [RES_W-1:0] a2_q, a2_d, t_q, t_d, a3_q, a3_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  logic [RES_W-1:0] q1_red, q2_red, q3_red;
  logic [SW-1:0]    diff12, diff13, diff23;
  logic [RED_W-1:0] prod12, prod13, prod23;
  logic [RES_W-1:0] a2_red, t_red, a3_red;
  logic [OUT_W-1:0] acc_sum;

  // Input residue reduction.
  rns_mod_reduce #(.Modulus(M1)) u_red_r1 (.val_i(RED_W'(r1)), .res_o(q1_red));
  rns_mod_reduce #(.Modulus(M2)) u_red_r2 (.val_i(RED_W'(r2)), .res_o(q2_red));
  rns_mod_reduce #(.Modulus(M3)) u_red_r3 (.val_i(RED_W'(r3)), .res_o(q3_red));

  // Modular subtracts. a1 = q1 < M1 < M2 < M3, so a1 is already reduced mod M2 and M3,
  // and a2 < M2 < M3 likewise. Adding m before subtracting keeps intermediates non-negative.
  always_comb begin
    diff12 = (q2_q >= q1_q) ? SW'(q2_q) - SW'(q1_q) : (SW'(q2_q) + SW'(M2)) - SW'(q1_q);
    diff13 = (q3_q >= q1_q) ? SW'(q3_q) - SW'(q1_q) : (SW'(q3_q) + SW'(M3)) - SW'(q1_q);
    diff23 = (t_q >= a2_q)  ? SW'(t_q) - SW'(a2_q)  : (SW'(t_q) + SW'(M3)) - SW'(a2_q);
    prod12 = RED_W'(diff12) * RED_W'(INV12);
    prod13 = RED_W'(diff13) * RED_W'(INV13);
    prod23 = RED_W'(diff23) * RED_W'(INV23);
  end

  rns_mod_reduce #(.Modulus(M2)) u_red_a2 (.val_i(prod12), .res_o(a2_red));
  rns_mod_reduce #(.Modulus(M3)) u_red_t  (.val_i(prod13), .res_o(t_red));
  rns_mod_reduce #(.Modulus(M3)) u_red_a3 (.val_i(prod23), .res_o(a3_red));

  // X = a1 + a2*M1 + a3*M1*M2; max 2 + 12 + 90 = 104 so OUT_W never overflows.
  always_comb begin
    acc_sum = OUT_W'(q1_q) + OUT_W'(a2_q) * OUT_W'(M1) + OUT_W'(a3_q) * OUT_W'(M1 * M2);
  end

  always_comb begin
    state_d     = state_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    q3_d        = q3_q;
    err_d       = err_q;
    a2_d        = a2_q;
    t_d         = t_q;
    a3_d        = a3_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          q1_d    = q1_red;
          q2_d    = q2_red;
          q3_d    = q3_red;
          err_d   = (r1 >= RES_W'(M1)) | (r2 >= RES_W'(M2)) | (r3 >= RES_W'(M3));
          state_d = StA2;
        end
      end
      StA2: begin
        a2_d    = a2_red;
        t_d     = t_red;
        state_d = StA3;
      end
      StA3: begin
        a3_d    = a3_red;
        state_d = StAcc;
      end
      StAcc: begin
        out_data_d  = acc_sum;
        out_err_d   = err_q;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      q1_q        <= '0;
      q2_q        <= '0;
      q3_q        <= '0;
      err_q       <= 1'b0;
      a2_q        <= '0;
      t_q         <= '0;
      a3_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      q3_q        <= q3_d;
      err_q       <= err_d;
      a2_q        <= a2_d;
      t_q         <= t_d;
      a3_q        <= a3_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule
